// File: rtl/dds_ctrl_pkg.sv
// Shared types, step table and tuning-word arithmetic for the DDS frequency controller.
package dds_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CALC,
    ST_LOAD,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  localparam int unsigned TMR_W = 32;

  // Index 0 is the finest step (1 Hz at 100 MHz), index 3 the coarsest (1 kHz).
  localparam logic [3:0][31:0] STEP_LUT = {32'd42950, 32'd4295, 32'd430, 32'd43};

  // Add or subtract one step with a carry/borrow bit, then clamp into [lo, hi].
  function automatic logic [31:0] next_ftw(
    input logic [31:0] cur,
    input logic [31:0] step,
    input logic        up,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    logic [32:0] sum;
    logic [31:0] res;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, step};
    end else begin
      sum = {1'b0, cur} - {1'b0, step};
    end
    res = sum[31:0];
    if (up && (sum > {1'b0, hi})) begin
      res = hi;
    end
    if (!up && (sum[32] || (sum[31:0] < lo))) begin
      res = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/dds_rpt_timer.sv
// Auto-repeat timer: the first interval after a clear is RPT_DLY cycles, later ones RPT_PER.
module dds_rpt_timer
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned RPT_DLY = 50_000_000,
  parameter int unsigned RPT_PER = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [TMR_W-1:0] DLY_LD = TMR_W'(RPT_DLY - 1);
  localparam logic [TMR_W-1:0] PER_LD = TMR_W'(RPT_PER - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             repeat_q, repeat_d;

  assign tick_o = active_q && (cnt_q == '0);

  // repeat_q remembers that one tick already fired, so the next start uses the short period.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    repeat_d = repeat_q;
    if (clear_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
      repeat_d = 1'b0;
    end else if (start_i) begin
      active_d = 1'b1;
      cnt_d    = repeat_q ? PER_LD : DLY_LD;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
        repeat_d = 1'b1;
      end else begin
        cnt_d = cnt_q - TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      repeat_q <= repeat_d;
    end
  end

endmodule

// File: rtl/dds_freq_ctrl.sv
// Button-driven DDS tuning-word controller with clamping, settle time and auto-repeat.
module dds_freq_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter logic [31:0] FTW_INIT   = 32'd42950,
  parameter logic [31:0] FTW_MIN    = 32'd43,
  parameter logic [31:0] FTW_MAX    = 32'h4000_0000,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned RPT_DLY    = 50_000_000,
  parameter int unsigned RPT_PER    = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        up_btn_i,
  input  logic        down_btn_i,
  input  logic [1:0]  step_sel_i,
  output logic [31:0] frequency_o,
  output logic        freq_up_trigger_o,
  output logic        freq_down_trigger_o,
  output logic        busy_o,
  output logic        at_limit_o
);

  localparam int unsigned   SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [31:0]   freq_q, freq_d;
  logic [31:0]   next_q, next_d;
  logic          up_trig_q, up_trig_d;
  logic          dn_trig_q, dn_trig_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          up_lvl_q, dn_lvl_q;
  logic          up_rise_q, dn_rise_q;
  logic          origin_held, other_held;
  logic          tmr_start, tmr_clear, tmr_tick;

  // Button level and rising-edge registers; the edge register is the first latency stage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      up_lvl_q  <= 1'b0;
      dn_lvl_q  <= 1'b0;
      up_rise_q <= 1'b0;
      dn_rise_q <= 1'b0;
    end else begin
      up_lvl_q  <= up_btn_i;
      dn_lvl_q  <= down_btn_i;
      up_rise_q <= up_btn_i & ~up_lvl_q;
      dn_rise_q <= down_btn_i & ~dn_lvl_q;
    end
  end

  assign origin_held = ((dir_q == DIR_UP) && up_lvl_q) || ((dir_q == DIR_DOWN) && dn_lvl_q);
  assign other_held  = ((dir_q == DIR_UP) && dn_lvl_q) || ((dir_q == DIR_DOWN) && up_lvl_q);

  dds_rpt_timer #(
    .RPT_DLY(RPT_DLY),
    .RPT_PER(RPT_PER)
  ) u_rpt_timer (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .start_i(tmr_start),
    .clear_i(tmr_clear),
    .tick_o (tmr_tick)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    freq_d    = freq_q;
    next_d    = next_q;
    up_trig_d = 1'b0;
    dn_trig_d = 1'b0;
    cnt_d     = cnt_q;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        freq_d    = FTW_INIT;
        up_trig_d = 1'b1;
        dir_d     = DIR_NONE;
        cnt_d     = '0;
        tmr_clear = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (up_rise_q && !dn_rise_q) begin
          dir_d   = DIR_UP;
          state_d = ST_CALC;
        end else if (dn_rise_q && !up_rise_q) begin
          dir_d   = DIR_DOWN;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        next_d  = next_ftw(freq_q, STEP_LUT[step_sel_i], dir_q == DIR_UP, FTW_MIN, FTW_MAX);
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (next_q != freq_q) begin
          freq_d    = next_q;
          up_trig_d = (dir_q == DIR_UP);
          dn_trig_d = (dir_q == DIR_DOWN);
        end
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (origin_held) begin
            tmr_start = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_HOLD: begin
        // Leaving the hold takes priority over a repeat tick in the same cycle.
        if (!origin_held || other_held) begin
          tmr_clear = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmr_tick) begin
          state_d = ST_CALC;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_INIT;
      dir_q     <= DIR_NONE;
      freq_q    <= FTW_INIT;
      next_q    <= '0;
      up_trig_q <= 1'b0;
      dn_trig_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      freq_q    <= freq_d;
      next_q    <= next_d;
      up_trig_q <= up_trig_d;
      dn_trig_q <= dn_trig_d;
      cnt_q     <= cnt_d;
    end
  end

  assign frequency_o         = freq_q;
  assign freq_up_trigger_o   = up_trig_q;
  assign freq_down_trigger_o = dn_trig_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign at_limit_o          = (freq_q == FTW_MIN) || (freq_q == FTW_MAX);

endmodule
